// File: rtl/client_axis_tx_pkg.sv
// Shared definitions for the client egress transmitter: default sizing, counter width
// and the framing FSM state encoding.
package client_axis_tx_pkg;

    localparam int DEF_N       = 2;
    localparam int DEF_D_W     = 32;
    localparam int DEF_A_W     = $clog2(DEF_N) + 1;
    localparam int DEF_FLIT_W  = DEF_A_W + DEF_D_W;
    localparam int DEF_PKT_LEN = 4;
    localparam int DEF_FIFO_D  = 4;

    localparam int CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } txState_t;

endpackage

// File: rtl/client_axis_tx_if.sv
// AXI-stream-style write channel from the client transmitter into the router.
interface client_axis_tx_if
    import client_axis_tx_pkg::*;
#(
    parameter int W = DEF_FLIT_W
);

    logic [W-1:0] wdata;
    logic         wvalid;
    logic         wready;
    logic         wlast;

    modport master (output wdata, output wvalid, output wlast, input wready);
    modport slave  (input wdata, input wvalid, input wlast, output wready);

endinterface

// File: rtl/client_tx_fifo.sv
// Small synchronous FIFO with occupancy count; head word is read combinationally.
module client_tx_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= i_data;
    end

endmodule

// File: rtl/client_axis_tx.sv
// Client egress transmitter: buffers client flits, frames fixed-length packets and drives
// a registered stream master. Optional stall counter enabled by CLIENT_TX_STALL_STATS_EN.
module client_axis_tx
    import client_axis_tx_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int D_W     = DEF_D_W,
    parameter int A_W     = $clog2(N) + 1,
    parameter int PKT_LEN = DEF_PKT_LEN,
    parameter int FIFO_D  = DEF_FIFO_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [A_W+D_W-1:0]    c_o,
    input  logic                  c_o_v,
    output logic                  c_o_bp,
    client_axis_tx_if.master      m_axis_c,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic                  busy,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int FW = A_W + D_W;
    localparam int BW = $clog2(PKT_LEN) + 1;

    logic [FW-1:0]           w_head;
    logic [$clog2(FIFO_D):0] w_count;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_xfer;
    logic                    w_beatLast;

    txState_t                r_state;
    txState_t                w_nextState;
    logic [BW-1:0]           r_beat;
    logic [BW-1:0]           w_beatNext;
    logic [A_W-1:0]          r_dest;
    logic [A_W-1:0]          w_destNext;
    logic [FW-1:0]           w_loadData;
    logic                    w_loadLast;

    logic [FW-1:0]           r_wdata;
    logic                    r_wvalid;
    logic                    r_wlast;
    logic [CNT_W-1:0]        r_pktCnt;

    assign w_accept   = ce && c_o_v && !w_full;
    assign w_xfer     = r_wvalid && m_axis_c.wready;
    assign w_load     = ce && !w_empty && (!r_wvalid || m_axis_c.wready);
    assign w_beatLast = (r_beat == BW'(PKT_LEN - 1));

    client_tx_fifo #(
        .W     (FW),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_data  (c_o),
        .i_pop   (w_load),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_dest  <= '0;
        end else if (w_load) begin
            r_state <= w_nextState;
            r_beat  <= w_beatNext;
            r_dest  <= w_destNext;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (PKT_LEN > 1) w_nextState = BODY;
            BODY:    if (w_beatLast) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Body flits inherit the destination latched from the packet's first flit.
    always_comb begin
        w_loadData = w_head;
        w_loadLast = 1'b0;
        w_beatNext = r_beat;
        w_destNext = r_dest;
        case (r_state)
            IDLE: begin
                w_destNext = w_head[FW-1:D_W];
                w_loadLast = (PKT_LEN == 1);
                w_beatNext = (PKT_LEN == 1) ? '0 : BW'(1);
            end
            BODY: begin
                w_loadData = {r_dest, w_head[D_W-1:0]};
                w_loadLast = w_beatLast;
                w_beatNext = w_beatLast ? '0 : r_beat + BW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdata  <= '0;
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
        end else if (w_load) begin
            r_wdata  <= w_loadData;
            r_wlast  <= w_loadLast;
            r_wvalid <= 1'b1;
        end else if (w_xfer) begin
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                   r_pktCnt <= '0;
        else if (w_xfer && r_wlast) r_pktCnt <= r_pktCnt + CNT_W'(1);
    end

`ifdef CLIENT_TX_STALL_STATS_EN
    logic [CNT_W-1:0] r_stallCnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_stallCnt <= '0;
        else if (r_wvalid && !m_axis_c.wready && (r_stallCnt != '1))
            r_stallCnt <= r_stallCnt + CNT_W'(1);
    end

    assign stall_cnt = r_stallCnt;
`else
    assign stall_cnt = '0;
`endif

    assign c_o_bp          = w_full;
    assign busy            = (w_count != '0) || r_wvalid || (r_state == BODY);
    assign pkt_cnt         = r_pktCnt;
    assign m_axis_c.wdata  = r_wdata;
    assign m_axis_c.wvalid = r_wvalid;
    assign m_axis_c.wlast  = r_wlast;

endmodule

// File: tb/tb_client_axis_tx.sv
// Directed self-checking bench for client_axis_tx (default sizes: 2-bit addr, 32-bit data,
// 4-flit packets, 4-deep FIFO). Expected stall count follows CLIENT_TX_STALL_STATS_EN.
module tb_client_axis_tx;

    localparam int FW = 34;

`ifdef CLIENT_TX_STALL_STATS_EN
    localparam logic [15:0] EXP_STALL = 16'd7;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [FW-1:0] c_o;
    logic          c_o_v;
    logic          c_o_bp;
    logic [15:0]   pkt_cnt;
    logic          busy;
    logic [15:0]   stall_cnt;

    int checkCount = 0;
    int errorCount = 0;

    logic [FW-1:0] inFlit  [8];
    logic [FW-1:0] expFlit [8];
    logic          expLast [8];

    client_axis_tx_if #(.W(FW)) axisIf ();

    client_axis_tx dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .c_o       (c_o),
        .c_o_v     (c_o_v),
        .c_o_bp    (c_o_bp),
        .m_axis_c  (axisIf),
        .pkt_cnt   (pkt_cnt),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mkFlit(input logic [1:0] a, input logic [31:0] d);
        return {a, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [FW-1:0] f);
        c_o_v = v;
        c_o   = f;
    endtask

    // Outputs are sampled 1ns after the active edge, inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes n flits back-to-back with wready high and checks each one appears one cycle
    // after the next push, ending with wvalid low once the last flit has transferred.
    task automatic streamPacket(input int n, input string name);
        for (int i = 0; i <= n; i++) begin
            if (i < n) applyStimulus(1'b1, inFlit[i]);
            else       applyStimulus(1'b0, '0);
            tick();
            if (i == 0) begin
                checkOutput($sformatf("%s.lat", name), axisIf.wvalid, 1'b0);
            end else begin
                checkOutput($sformatf("%s.v%0d", name, i - 1), axisIf.wvalid, 1'b1);
                checkOutput($sformatf("%s.d%0d", name, i - 1), axisIf.wdata, expFlit[i - 1]);
                checkOutput($sformatf("%s.l%0d", name, i - 1), axisIf.wlast, expLast[i - 1]);
            end
        end
        tick();
        checkOutput($sformatf("%s.drain", name), axisIf.wvalid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b1;
        axisIf.wready = 1'b1;
        applyStimulus(1'b0, '0);
        tick();
        tick();
        checkOutput("rst.wvalid", axisIf.wvalid, 1'b0);
        checkOutput("rst.wlast", axisIf.wlast, 1'b0);
        checkOutput("rst.wdata", axisIf.wdata, '0);
        checkOutput("rst.pkt", pkt_cnt, 16'd0);
        checkOutput("rst.stall", stall_cnt, 16'd0);
        checkOutput("rst.busy", busy, 1'b0);
        checkOutput("rst.bp", c_o_bp, 1'b0);
        rst = 1'b0;

        $display("[TB] test 1: basic packet");
        for (int i = 0; i < 4; i++) begin
            inFlit[i]  = mkFlit(2'd1, 32'(i));
            expFlit[i] = mkFlit(2'd1, 32'(i));
            expLast[i] = (i == 3);
        end
        streamPacket(4, "t1");
        checkOutput("t1.pkt", pkt_cnt, 16'd1);
        checkOutput("t1.busy", busy, 1'b0);

        $display("[TB] test 2: address override");
        for (int i = 0; i < 8; i++) begin
            inFlit[i]  = mkFlit((i == 0 || i >= 5) ? 2'd1 : 2'd0, 32'(i));
            expFlit[i] = mkFlit((i < 4) ? 2'd1 : 2'd0, 32'(i));
            expLast[i] = (i == 3) || (i == 7);
        end
        streamPacket(8, "t2");
        checkOutput("t2.pkt", pkt_cnt, 16'd3);

        $display("[TB] test 3: downstream backpressure");
        axisIf.wready = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            applyStimulus(1'b1, mkFlit(2'd1, 32'h30 + 32'((e - 1 > 5) ? 5 : e - 1)));
            tick();
            if (e == 1) begin
                checkOutput("t3.lat", axisIf.wvalid, 1'b0);
            end else begin
                checkOutput($sformatf("t3.hold.v%0d", e), axisIf.wvalid, 1'b1);
                checkOutput($sformatf("t3.hold.d%0d", e), axisIf.wdata, mkFlit(2'd1, 32'h30));
            end
            checkOutput($sformatf("t3.bp%0d", e), c_o_bp, (e >= 5));
        end
        axisIf.wready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) applyStimulus(1'b1, mkFlit(2'd1, 32'h30 + 32'((k <= 1) ? 5 : k + 4)));
            else       applyStimulus(1'b0, '0);
            tick();
            if (k == 0) checkOutput("t3.bpDrop", c_o_bp, 1'b0);
            if (k < 7) begin
                checkOutput($sformatf("t3.v%0d", k + 1), axisIf.wvalid, 1'b1);
                checkOutput($sformatf("t3.d%0d", k + 1), axisIf.wdata, mkFlit(2'd1, 32'h31 + 32'(k)));
                checkOutput($sformatf("t3.l%0d", k + 1), axisIf.wlast, (k == 2) || (k == 6));
            end else begin
                checkOutput("t3.drain", axisIf.wvalid, 1'b0);
            end
        end
        checkOutput("t3.pkt", pkt_cnt, 16'd5);

        $display("[TB] test 4: clock enable mid-packet");
        applyStimulus(1'b1, mkFlit(2'd0, 32'h40));
        tick();
        checkOutput("t4.lat", axisIf.wvalid, 1'b0);
        applyStimulus(1'b1, mkFlit(2'd0, 32'h41));
        tick();
        checkOutput("t4.v0", axisIf.wvalid, 1'b1);
        checkOutput("t4.d0", axisIf.wdata, mkFlit(2'd0, 32'h40));
        ce = 1'b0;
        applyStimulus(1'b1, mkFlit(2'd0, 32'h42));
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput($sformatf("t4.frozen.v%0d", c), axisIf.wvalid, 1'b0);
            checkOutput($sformatf("t4.frozen.busy%0d", c), busy, 1'b1);
        end
        checkOutput("t4.frozen.pkt", pkt_cnt, 16'd5);
        ce = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 0)      applyStimulus(1'b1, mkFlit(2'd0, 32'h42));
            else if (k == 1) applyStimulus(1'b1, mkFlit(2'd0, 32'h43));
            else             applyStimulus(1'b0, '0);
            tick();
            if (k < 3) begin
                checkOutput($sformatf("t4.v%0d", k + 1), axisIf.wvalid, 1'b1);
                checkOutput($sformatf("t4.d%0d", k + 1), axisIf.wdata, mkFlit(2'd0, 32'h41 + 32'(k)));
                checkOutput($sformatf("t4.l%0d", k + 1), axisIf.wlast, (k == 2));
            end else begin
                checkOutput("t4.drain", axisIf.wvalid, 1'b0);
            end
        end
        checkOutput("t4.pkt", pkt_cnt, 16'd6);

        $display("[TB] test 5: reset mid-packet");
        applyStimulus(1'b1, mkFlit(2'd1, 32'h50));
        tick();
        applyStimulus(1'b1, mkFlit(2'd1, 32'h51));
        tick();
        applyStimulus(1'b0, '0);
        tick();
        checkOutput("t5.pre.d", axisIf.wdata, mkFlit(2'd1, 32'h51));
        rst = 1'b1;
        tick();
        checkOutput("t5.rst.wvalid", axisIf.wvalid, 1'b0);
        checkOutput("t5.rst.wdata", axisIf.wdata, '0);
        checkOutput("t5.rst.wlast", axisIf.wlast, 1'b0);
        checkOutput("t5.rst.pkt", pkt_cnt, 16'd0);
        checkOutput("t5.rst.stall", stall_cnt, 16'd0);
        checkOutput("t5.rst.busy", busy, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inFlit[i]  = mkFlit(2'd0, 32'h60 + 32'(i));
            expFlit[i] = mkFlit(2'd0, 32'h60 + 32'(i));
            expLast[i] = (i == 3);
        end
        streamPacket(4, "t5");
        checkOutput("t5.pkt", pkt_cnt, 16'd1);

        $display("[TB] test 6: stall statistics");
        axisIf.wready = 1'b0;
        applyStimulus(1'b1, mkFlit(2'd1, 32'h70));
        tick();
        applyStimulus(1'b0, '0);
        tick();
        checkOutput("t6.v", axisIf.wvalid, 1'b1);
        for (int c = 0; c < 7; c++) tick();
        checkOutput("t6.stall", stall_cnt, EXP_STALL);
        checkOutput("t6.hold", axisIf.wdata, mkFlit(2'd1, 32'h70));
        axisIf.wready = 1'b1;
        tick();
        checkOutput("t6.xfer", axisIf.wvalid, 1'b0);
        checkOutput("t6.stallAfter", stall_cnt, EXP_STALL);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
